// File: rtl/leddc_tx_if.sv
// Word-input handshake between the frame-buffer fetch logic and leddc_tx.
`timescale 1ns/1ps
interface leddc_tx_if;
   logic [15:0] din;
   logic        din_valid;
   logic        din_ready;

   modport master (output din, output din_valid, input din_ready);
   modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/leddc_tx.sv
// LED driver link transmitter: buffers one 16-bit word, serialises it LSB-first on DAI
// under a divided DCK, frames it with DEN and marks vertical blank with Vsync.
`timescale 1ns/1ps
module leddc_tx #(
   parameter int DIV         = 2,
   parameter int FRAME_WORDS = 256,
   parameter int GAP         = 1,
   parameter int VS_LOW      = 16
) (
   input  logic        CLK,
   input  logic        rst_n,
   input  logic        en,
   leddc_tx_if.slave   s_in,
   output logic        DCK,
   output logic        DAI,
   output logic        DEN,
   output logic        Vsync,
   output logic        frame_done,
   output logic        busy
);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int GW = $clog2(GAP + 1);
   localparam int VW = $clog2(VS_LOW + 1);
   localparam int WW = $clog2(FRAME_WORDS + 1);

   typedef enum logic [1:0] {S_IDLE, S_GAP, S_SHIFT, S_VBLANK} state_t;

   state_t          r_state, w_state_nxt;
   logic [DW-1:0]   r_div;
   logic            r_dck;
   logic [GW-1:0]   r_gap;
   logic [VW-1:0]   r_vs;
   logic [3:0]      r_bit;
   logic [WW-1:0]   r_wcnt;
   logic            r_full, r_den, r_vsync, r_fd;
   logic [15:0]     r_hold, r_sh;

   logic            w_tc, w_bnd, w_gap_ok;
   logic [GW-1:0]   w_gap_inc;
   logic            w_load, w_step, w_wend, w_vb_in, w_vb_out, w_accept;

   assign w_tc      = (r_div == DW'(DIV - 1));
   // A period boundary is the CLK edge on which DCK falls.
   assign w_bnd     = (r_state != S_IDLE) && w_tc && r_dck;
   assign w_gap_inc = (r_gap >= GW'(GAP)) ? r_gap : r_gap + 1'b1;
   assign w_gap_ok  = (w_gap_inc >= GW'(GAP));
   assign w_accept  = s_in.din_valid && !r_full;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_wend      = 1'b0;
      w_vb_in     = 1'b0;
      w_vb_out    = 1'b0;
      case (r_state)
         S_IDLE: if (en) w_state_nxt = S_GAP;
         S_GAP: begin
            if (w_bnd && w_gap_ok) begin
               if (!en) begin
                  w_state_nxt = S_IDLE;
               end else if (r_full) begin
                  w_state_nxt = S_SHIFT;
                  w_load      = 1'b1;
               end
            end
         end
         S_SHIFT: begin
            if (w_bnd) begin
               if (r_bit == 4'd15) begin
                  w_wend = 1'b1;
                  if (r_wcnt == WW'(FRAME_WORDS - 1)) begin
                     w_state_nxt = S_VBLANK;
                     w_vb_in     = 1'b1;
                  end else begin
                     w_state_nxt = S_GAP;
                  end
               end else begin
                  w_step = 1'b1;
               end
            end
         end
         S_VBLANK: begin
            if (w_bnd && (r_vs == VW'(VS_LOW - 1))) begin
               w_state_nxt = S_GAP;
               w_vb_out    = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_dck   <= 1'b0;
         r_gap   <= '0;
         r_vs    <= '0;
         r_bit   <= '0;
         r_wcnt  <= '0;
         r_full  <= 1'b0;
         r_den   <= 1'b0;
         r_vsync <= 1'b0;
         r_fd    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_fd    <= w_vb_in;
         if (r_state == S_IDLE) begin
            r_div <= '0;
            r_dck <= 1'b0;
         end else if (w_tc) begin
            r_div <= '0;
            r_dck <= ~r_dck;
         end else begin
            r_div <= r_div + 1'b1;
         end
         if (r_state != S_GAP) r_gap <= '0;
         else if (w_bnd)       r_gap <= w_gap_inc;
         if (r_state != S_VBLANK) r_vs <= '0;
         else if (w_bnd)          r_vs <= r_vs + 1'b1;
         if (w_load)      r_bit <= '0;
         else if (w_step) r_bit <= r_bit + 1'b1;
         if (w_vb_in)     r_wcnt <= '0;
         else if (w_wend) r_wcnt <= r_wcnt + 1'b1;
         if (w_load)        r_full <= 1'b0;
         else if (w_accept) r_full <= 1'b1;
         if (w_load)      r_den <= 1'b1;
         else if (w_wend) r_den <= 1'b0;
         // Leaving for IDLE drops the frame level so the receiver sees a fresh frame on restart.
         if (w_vb_out)                                r_vsync <= 1'b1;
         else if (w_vb_in || w_state_nxt == S_IDLE)   r_vsync <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_accept) r_hold <= s_in.din;
      if (w_load)      r_sh <= r_hold;
      else if (w_step) r_sh <= {1'b0, r_sh[15:1]};
   end

   assign s_in.din_ready = ~r_full;
   assign DCK            = r_dck;
   assign DAI            = r_den & r_sh[0];
   assign DEN            = r_den;
   assign Vsync          = r_vsync;
   assign frame_done     = r_fd;
   assign busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_leddc_tx.sv
// Bench for leddc_tx: decodes the serial link at DCK rises into words, gaps and blanks,
// and compares them with the words pushed and the frame rules.
`timescale 1ns/1ps
module tb_leddc_tx;
   logic CLK = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic DCK, DAI, DEN, Vsync, frame_done, busy;

   leddc_tx_if s_if ();

   leddc_tx #(.DIV(2), .FRAME_WORDS(4), .GAP(1), .VS_LOW(16)) dut (
      .CLK(CLK), .rst_n(rst_n), .en(en), .s_in(s_if.slave),
      .DCK(DCK), .DAI(DAI), .DEN(DEN), .Vsync(Vsync),
      .frame_done(frame_done), .busy(busy)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   logic [15:0] rx_q[$];
   int          len_q[$];
   int          gap_q[$];
   logic        vsq[$];
   int          vb_len_q[$];
   logic [15:0] exp_q[$];
   int fd_cnt = 0, rfall = 0, p_bad = 0, rise_cnt = 0;
   int m_cnt = 0, m_gap = 0, vb_rises = 0;
   logic [15:0] m_acc = '0;
   logic m_prev = 1'b0, in_vb = 1'b0, prev_rdy = 1'b1;
   time  last_rise = 0;

   typedef struct {
      logic [15:0] w;
      int          ones;
      logic        lsb;
      logic        msb;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Link monitor, sampled on the falling CLK edge so every DUT output is settled.
   initial begin
      forever begin
         @(negedge CLK);
         if (!rst_n) begin
            m_cnt = 0; m_gap = 0; m_prev = 1'b0; in_vb = 1'b0; m_acc = '0;
         end else begin
            if (frame_done) begin fd_cnt++; in_vb = 1'b1; vb_rises = 0; end
            if (prev_rdy && !s_if.din_ready) rfall++;
            if (DCK && !m_prev) begin
               rise_cnt++;
               if (m_cnt > 0 && ($time - last_rise) != 40) p_bad++;
               last_rise = $time;
               if (in_vb) begin
                  if (Vsync) begin vb_len_q.push_back(vb_rises); in_vb = 1'b0; end
                  else vb_rises++;
               end
               if (DEN) begin
                  if (m_cnt == 0) begin gap_q.push_back(m_gap); vsq.push_back(Vsync); end
                  if (m_cnt < 16) m_acc[m_cnt] = DAI;
                  m_cnt++;
                  m_gap = 0;
               end else begin
                  if (m_cnt > 0) begin
                     rx_q.push_back(m_acc); len_q.push_back(m_cnt);
                     m_cnt = 0; m_acc = '0;
                  end
                  m_gap++;
               end
            end
            m_prev = DCK;
         end
         prev_rdy = s_if.din_ready;
      end
   end

   task automatic push(input logic [15:0] w);
      int t = 0;
      s_if.din = w;
      s_if.din_valid = 1'b1;
      while (!s_if.din_ready && t < 3000) begin @(negedge CLK); t++; end
      if (t >= 3000) chk("push_timeout", 32'd0, 32'd1);
      @(negedge CLK);
      s_if.din_valid = 1'b0;
      exp_q.push_back(w);
   endtask

   task automatic wait_words(input int n);
      int t = 0;
      while (rx_q.size() < n && t < 8000) begin @(negedge CLK); t++; end
      if (t >= 8000) chk("rx_timeout", rx_q.size(), n);
   endtask

   initial begin
      vec_t vecs[6];
      int   seq[16];
      int   n0, r0, den_bad, t, mg, base, rc;
      logic [15:0] w;

      s_if.din = '0;
      s_if.din_valid = 1'b0;
      vecs[0] = '{16'hFFFF, 16, 1'b1, 1'b1};
      vecs[1] = '{16'h0000, 0, 1'b0, 1'b0};
      vecs[2] = '{16'h1234, 5, 1'b0, 1'b0};
      vecs[3] = '{16'h8001, 2, 1'b1, 1'b1};
      vecs[4] = '{16'h7FFE, 14, 1'b0, 1'b0};
      vecs[5] = '{16'h00F0, 4, 1'b0, 1'b0};
      seq = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

      // Reset values
      repeat (3) @(negedge CLK);
      chk("rst_DCK", DCK, 0);   chk("rst_DAI", DAI, 0);   chk("rst_DEN", DEN, 0);
      chk("rst_Vsync", Vsync, 0); chk("rst_frame_done", frame_done, 0);
      chk("rst_busy", busy, 0); chk("rst_din_ready", s_if.din_ready, 1);
      rst_n = 1'b1;
      den_bad = 0;
      repeat (100) begin @(negedge CLK); if (DCK !== 1'b0 || busy !== 1'b0) den_bad++; end
      chk("idle_no_dck", den_bad, 0);
      chk("idle_no_rise", rise_cnt, 0);

      // Single word A5C3
      en = 1'b1;
      push(16'hA5C3);
      wait_words(1);
      chk("w1_data", rx_q[0], 16'hA5C3);
      for (int i = 0; i < 16; i++) begin
         w = rx_q[0];
         chk($sformatf("w1_bit%0d", i), w[i], seq[i]);
      end
      chk("w1_den_len", len_q[0], 16);
      chk("w1_period", p_bad, 0);

      // Back-to-back with valid held
      r0 = rfall;
      push(16'h0001);
      push(16'h8000);
      wait_words(3);
      chk("b2b_w2", rx_q[1], 16'h0001);
      chk("b2b_w3", rx_q[2], 16'h8000);
      chk("b2b_gap", gap_q[2], 1);
      chk("b2b_ready_falls", rfall - r0, 2);

      // Underflow: long idle input, DEN must stay low
      den_bad = 0;
      repeat (40) begin @(negedge CLK); if (DEN !== 1'b0) den_bad++; end
      chk("uflow_den_low", den_bad, 0);
      chk("uflow_busy", busy, 1);
      push(16'h1234);
      wait_words(4);
      chk("uflow_w4", rx_q[3], 16'h1234);
      chk("uflow_len", len_q[3], 16);

      // Frame end after 4th word
      t = 0;
      while (vb_len_q.size() < 1 && t < 2000) begin @(negedge CLK); t++; end
      chk("vb_seen", vb_len_q.size(), 1);
      chk("fd_once", fd_cnt, 1);
      if (vb_len_q.size() > 0) chk("vb_len", vb_len_q[0], 16);
      chk("vsync_high", Vsync, 1);

      // Table vectors, words 5..10
      for (int i = 0; i < 6; i++) begin
         push(vecs[i].w);
         wait_words(5 + i);
         w = rx_q[4 + i];
         chk($sformatf("vec%0d_data", i), w, vecs[i].w);
         chk($sformatf("vec%0d_ones", i), $countones(w), vecs[i].ones);
         chk($sformatf("vec%0d_lsb", i), w[0], vecs[i].lsb);
         chk($sformatf("vec%0d_msb", i), w[15], vecs[i].msb);
      end
      chk("w5_after_vsync", vsq[4], 1);
      chk("w5_gap_after_vb", gap_q[4] >= 17, 1);
      chk("fd_two", fd_cnt, 2);

      // Randomized words with random input gaps
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 30)) @(negedge CLK);
         push(16'($urandom));
      end
      wait_words(30);
      n0 = 0;
      for (int k = 0; k < 30; k++) begin
         if (rx_q[k] !== exp_q[k] || len_q[k] != 16 || vsq[k] !== (k >= 4)) n0++;
      end
      chk("rand_stream", n0, 0);
      mg = 99;
      for (int k = 1; k < 30; k++) if (gap_q[k] < mg) mg = gap_q[k];
      chk("min_gap", mg, 1);
      t = 0;
      while (fd_cnt < 7 && t < 2000) begin @(negedge CLK); t++; end
      chk("fd_count", fd_cnt, 30 / 4);
      chk("period_all", p_bad, 0);

      // en dropped at bit 5: word completes, then IDLE
      t = 0;
      while (in_vb && t < 2000) begin @(negedge CLK); t++; end
      s_if.din = 16'hC35A; s_if.din_valid = 1'b1;
      t = 0;
      while (!s_if.din_ready && t < 2000) begin @(negedge CLK); t++; end
      @(negedge CLK); s_if.din_valid = 1'b0;
      t = 0;
      while (m_cnt < 5 && t < 2000) begin @(negedge CLK); t++; end
      en = 1'b0;
      wait_words(31);
      chk("endrop_data", rx_q[30], 16'hC35A);
      chk("endrop_len", len_q[30], 16);
      t = 0;
      while (busy && t < 200) begin @(negedge CLK); t++; end
      chk("endrop_idle", busy, 0);
      chk("endrop_vsync0", Vsync, 0);
      rc = rise_cnt;
      repeat (50) @(negedge CLK);
      chk("endrop_dck_stopped", rise_cnt - rc, 0);

      // Reset asserted at bit 9 of a later word
      en = 1'b1;
      base = rx_q.size();
      s_if.din = 16'h5AA5; s_if.din_valid = 1'b1;
      t = 0;
      while (!s_if.din_ready && t < 2000) begin @(negedge CLK); t++; end
      @(negedge CLK); s_if.din_valid = 1'b0;
      t = 0;
      while (m_cnt < 9 && t < 2000) begin @(negedge CLK); t++; end
      chk("rst_mid_reached", m_cnt >= 9, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid_DEN", DEN, 0);  chk("rstmid_DCK", DCK, 0); chk("rstmid_DAI", DAI, 0);
      chk("rstmid_busy", busy, 0); chk("rstmid_ready", s_if.din_ready, 1);
      repeat (20) @(negedge CLK);
      rst_n = 1'b1;
      en = 1'b0;
      den_bad = 0;
      repeat (40) begin @(negedge CLK); if (DEN !== 1'b0) den_bad++; end
      chk("rstmid_no_den", den_bad, 0);
      chk("rstmid_no_word", rx_q.size(), base);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
